saida_serial_seq_uc: RTL and testbench

Parametrised control unit sequencing up to N_PALAVRAS words through the serial-output datapath mux into the serial transmitter. Per transaction it latches a word count, pulses the transmitter once per word, waits for `serial_enviado`, and advances the mux select. It adds continuous repeat, abort, and an optional per-word timeout. It sits between the system controller (`inicio`/`pronto`) and the transmitter/mux pair of the serial output path.

---
 rtl/saida_serial_pkg.sv | 18 +
 rtl/saida_serial_timeout.sv | 23 ++
 rtl/saida_serial_seq_uc.sv | 74 +++++++
 tb/tb_saida_serial_seq_uc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/saida_serial_pkg.sv
// saida_serial_pkg: state encoding and width helper for the serial-output control unit
package saida_serial_pkg;
  typedef enum logic [3:0] {
    INICIAL    = 4'b0000,
    PREPARA    = 4'b0001,
    DISPARA    = 4'b0010,
    ESPERA     = 4'b0011,
    INCREMENTA = 4'b0100,
    FIM        = 4'b0101,
    ABORTA     = 4'b0110
  } estado_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/saida_serial_timeout.sv
// saida_serial_timeout: loadable cycle counter flagging TIMEOUT-1 as terminal count
module saida_serial_timeout
  import saida_serial_pkg::*;
#(
  parameter int TIMEOUT = 8,
  localparam int W = clog2(TIMEOUT + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] valor,
  output logic         fim
);
  logic [W-1:0] cont;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cont <= '0;
    else if (clear) cont <= '0;
    else if (load) cont <= valor;
    else if (enable) cont <= cont + 1'b1;
  assign fim = cont == W'(TIMEOUT - 1);
endmodule

// File: rtl/saida_serial_seq_uc.sv
// saida_serial_seq_uc: sequences up to N_PALAVRAS words through the serial mux into the transmitter
module saida_serial_seq_uc
  import saida_serial_pkg::*;
#(
  parameter int N_PALAVRAS = 4,
  parameter int TIMEOUT = 0,
  localparam int SEL_W = clog2(N_PALAVRAS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [SEL_W:0]   quantidade,
  input  logic             continuo,
  input  logic             cancela,
  input  logic             serial_enviado,
  output logic             partida,
  output logic [SEL_W-1:0] selecao_mux,
  output logic             ocupado,
  output logic             pronto,
  output logic             abortado,
  output logic [3:0]       db_estado
);
  localparam logic [SEL_W:0] QTD_MAX = (SEL_W + 1)'(N_PALAVRAS);
  estado_t estado, proximo;
  logic [SEL_W:0] qtd;
  logic [SEL_W-1:0] indice;
  logic ultimo, estouro;
  assign ultimo = {1'b0, indice} == qtd - 1'b1;
  generate
    if (TIMEOUT != 0) begin : g_to
      saida_serial_timeout #(.TIMEOUT(TIMEOUT)) u_to (
        .clock(clock),
        .reset_n(reset_n),
        .clear(estado == PREPARA || estado == INCREMENTA),
        .load(1'b0),
        .enable(estado == ESPERA),
        .valor('0),
        .fim(estouro)
      );
    end else begin : g_sem_to
      assign estouro = 1'b0;
    end
  endgenerate
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado <= INICIAL;
      qtd <= '0;
      indice <= '0;
    end else begin
      estado <= proximo;
      if (estado == INICIAL && inicio) qtd <= quantidade > QTD_MAX ? QTD_MAX : quantidade;
      // index only advances on a clean, non-final handshake so the mux never glitches
      if (estado == PREPARA) indice <= '0;
      else if (estado == ESPERA && !cancela && serial_enviado && !ultimo) indice <= indice + 1'b1;
    end
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:    proximo = inicio ? PREPARA : INICIAL;
      PREPARA:    proximo = cancela ? ABORTA : qtd == '0 ? FIM : DISPARA;
      DISPARA:    proximo = cancela ? ABORTA : ESPERA;
      ESPERA:     proximo = cancela ? ABORTA : serial_enviado ? (ultimo ? FIM : INCREMENTA) : estouro ? ABORTA : ESPERA;
      INCREMENTA: proximo = cancela ? ABORTA : DISPARA;
      FIM:        proximo = continuo ? PREPARA : INICIAL;
      default:    proximo = INICIAL;
    endcase
  end
  assign partida = estado == DISPARA;
  assign pronto = estado == FIM;
  assign abortado = estado == ABORTA;
  assign ocupado = estado != INICIAL;
  assign selecao_mux = indice;
  assign db_estado = estado;
endmodule

// File: tb/tb_saida_serial_seq_uc.sv
// tb_saida_serial_seq_uc: randomized transaction-level check of the serial-output control unit
module tb_saida_serial_seq_uc;
  localparam int NW = 4;
  logic clock = 0, reset_n = 0;
  logic inicio = 0, continuo = 0, cancela = 0, serial_enviado = 0;
  logic [2:0] quantidade = '0;
  logic partida, ocupado, pronto, abortado;
  logic [1:0] selecao_mux;
  logic [3:0] db_estado;
  logic inicio_t = 0;
  logic [2:0] quantidade_t = '0;
  logic partida_t, ocupado_t, pronto_t, abortado_t;
  logic [1:0] selecao_mux_t;
  logic [3:0] db_estado_t;
  int n_chk = 0, n_pass = 0;

  saida_serial_seq_uc #(.N_PALAVRAS(NW), .TIMEOUT(0)) dut (
    .clock(clock), .reset_n(reset_n), .inicio(inicio), .quantidade(quantidade),
    .continuo(continuo), .cancela(cancela), .serial_enviado(serial_enviado),
    .partida(partida), .selecao_mux(selecao_mux), .ocupado(ocupado),
    .pronto(pronto), .abortado(abortado), .db_estado(db_estado)
  );
  saida_serial_seq_uc #(.N_PALAVRAS(NW), .TIMEOUT(8)) dut_t (
    .clock(clock), .reset_n(reset_n), .inicio(inicio_t), .quantidade(quantidade_t),
    .continuo(1'b0), .cancela(1'b0), .serial_enviado(1'b0),
    .partida(partida_t), .selecao_mux(selecao_mux_t), .ocupado(ocupado_t),
    .pronto(pronto_t), .abortado(abortado_t), .db_estado(db_estado_t)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic send_word(input int w, input int n, input int g, input bit ab, input bit ab_env, output bit aborted);
    aborted = 0;
    tick;
    chk("partida", partida, 1);
    chk("sel_dispara", selecao_mux, w);
    for (int i = 0; i < g; i++) begin
      tick;
      chk("espera_quieto", {partida, pronto, abortado}, 0);
      chk("sel_espera", selecao_mux, w);
      inicio = 1'($urandom_range(0, 1));
    end
    inicio = 0;
    serial_enviado = ab ? ab_env : 1'b1;
    cancela = ab;
    tick;
    serial_enviado = 0;
    cancela = 0;
    if (ab) begin
      chk("abort_pulso", abortado, 1);
      chk("abort_sem_pronto", pronto, 0);
      chk("abort_sel", selecao_mux, w);
      tick;
      chk("abort_ocioso", {ocupado, abortado}, 0);
      aborted = 1;
    end else if (w == n - 1) begin
      chk("pronto", pronto, 1);
      chk("pronto_ocupado", ocupado, 1);
    end else begin
      chk("sel_incrementa", selecao_mux, w + 1);
      chk("incr_partida", partida, 0);
    end
  endtask

  task automatic run_txn(input int q, input int reps, input int ab_word, input bit ab_env, input int g_fix);
    int n;
    bit aborted;
    n = q > NW ? NW : q;
    inicio = 1;
    quantidade = 3'(q);
    tick;
    inicio = 0;
    quantidade = 3'($urandom);
    chk("prep_ocupado", ocupado, 1);
    chk("prep_partida", partida, 0);
    for (int r = 0; r <= reps; r++) begin
      if (n == 0) begin
        tick;
        chk("vazio_pronto", pronto, 1);
        chk("vazio_partida", partida, 0);
      end else begin
        for (int w = 0; w < n; w++) begin
          send_word(w, n, g_fix != 0 ? g_fix : int'($urandom_range(1, 6)), r == 0 && w == ab_word, ab_env, aborted);
          if (aborted) return;
        end
      end
      continuo = r < reps;
      cancela = 1'($urandom_range(0, 1));
      tick;
      continuo = 0;
      cancela = 0;
      if (r < reps) chk("cont_prepara", {ocupado, partida, pronto}, 3'b100);
      else chk("fim_ocioso", {ocupado, pronto, db_estado}, 0);
    end
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_main", {partida, ocupado, pronto, abortado, selecao_mux, db_estado}, 0);
    chk("rst_to", {partida_t, ocupado_t, pronto_t, abortado_t, selecao_mux_t, db_estado_t}, 0);
    reset_n = 1;
    tick;
    run_txn(4, 0, -1, 0, 5);
    run_txn(0, 0, -1, 0, 0);
    run_txn(7, 0, -1, 0, 0);
    run_txn(2, 1, -1, 0, 0);
    run_txn(4, 0, 1, 1, 0);
    run_txn(3, 0, 2, 0, 0);
    // no timeout configured: ESPERA must hold indefinitely
    inicio = 1;
    quantidade = 1;
    tick;
    inicio = 0;
    tick;
    chk("sem_to_partida", partida, 1);
    repeat (40) begin
      tick;
      chk("sem_to_espera", {ocupado, abortado}, 2'b10);
    end
    serial_enviado = 1;
    tick;
    serial_enviado = 0;
    chk("sem_to_pronto", pronto, 1);
    tick;
    chk("sem_to_ocioso", ocupado, 0);
    // TIMEOUT=8 instance: abort 8 cycles after entering ESPERA
    inicio_t = 1;
    quantidade_t = 1;
    tick;
    inicio_t = 0;
    tick;
    chk("to_partida", partida_t, 1);
    tick;
    chk("to_espera", db_estado_t, 4'b0011);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("to_cedo", abortado_t, 0);
    end
    tick;
    chk("to_abortado", abortado_t, 1);
    chk("to_sem_pronto", pronto_t, 0);
    tick;
    chk("to_ocioso", ocupado_t, 0);
    for (int k = 0; k < 40; k++) begin
      int q, n, reps, ab;
      q = $urandom_range(0, 7);
      n = q > NW ? NW : q;
      reps = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_txn(q, reps, ab, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) begin
        tick;
        chk("ocioso", {ocupado, partida, pronto, abortado}, 0);
      end
    end
    // asynchronous reset while word 2 is in flight
    inicio = 1;
    quantidade = 4;
    tick;
    inicio = 0;
    for (int w = 0; w < 2; w++) begin
      bit ab;
      send_word(w, 4, 2, 0, 0, ab);
    end
    tick;
    chk("rst_pre_partida", partida, 1);
    tick;
    chk("rst_pre_sel", selecao_mux, 2);
    #2 reset_n = 0;
    #1 chk("rst_async", {selecao_mux, ocupado, db_estado, partida, pronto, abortado}, 0);
    tick;
    tick;
    chk("rst_hold", {ocupado, pronto, abortado}, 0);
    reset_n = 1;
    tick;
    chk("rst_depois", {ocupado, pronto, abortado, selecao_mux}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
